// File: rtl/dzcpu_trace_buffer.sv
// On-chip trace capture for DZCPU/MMU events: timestamped records in a FIFO drained over valid/ready.
// Optional MMU address window filter enabled by defining TRACE_ADDR_FILTER_EN.
module dzcpu_trace_buffer #(
  parameter int DEPTH  = 16,
  parameter int TS_W   = 16,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  localparam int REC_W = 2 + TS_W + ADDR_W + DATA_W
) (
  input  logic                       iClock,
  input  logic                       iReset,
  input  logic                       iFlowStart,
  input  logic [ADDR_W-1:0]          iPc,
  input  logic [DATA_W-1:0]          iOpcode,
  input  logic                       iMmuWe,
  input  logic [ADDR_W-1:0]          iMmuAddr,
  input  logic [DATA_W-1:0]          iMmuData,
  input  logic                       iEof,
  input  logic [DATA_W-1:0]          iFlags,
  input  logic                       iArm,
  input  logic                       iTrigPcEn,
  input  logic [ADDR_W-1:0]          iTrigPc,
  input  logic                       iWrapMode,
`ifdef TRACE_ADDR_FILTER_EN
  input  logic [ADDR_W-1:0]          iFiltLo,
  input  logic [ADDR_W-1:0]          iFiltHi,
`endif
  output logic [1:0]                 oState,
  output logic                       oRdValid,
  input  logic                       iRdReady,
  output logic [REC_W-1:0]           oRdData,
  output logic [$clog2(DEPTH):0]     oCount,
  output logic [7:0]                 oDropCnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_ARMED   = 2'b01,
    ST_CAPTURE = 2'b10,
    ST_FROZEN  = 2'b11
  } state_t;

  state_t             state_q, state_d;
  logic [CW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [TS_W-1:0]    ts_q, ts_d;
  logic [7:0]         drop_q, drop_d;
  logic               rd_valid_q, rd_valid_d;
  logic [REC_W-1:0]   rd_data_q, rd_data_d;
  logic [REC_W-1:0]   mem_q [DEPTH];

  logic               mmu_pass;
  logic               trig_hit, cap_en;
  logic               mmu_cand, flow_cand, eof_cand;
  logic [1:0]         n_cand;
  logic [1:0]         type_sel;
  logic [ADDR_W-1:0]  addr_sel;
  logic [DATA_W-1:0]  data_sel;
  logic [REC_W-1:0]   wr_rec;
  logic               full, pop, push, ovw, mem_we;
  logic [CW-1:0]      next_count;
  logic [1:0]         drop_inc;
  logic [8:0]         drop_sum;
  logic [REC_W-1:0]   head;

`ifdef TRACE_ADDR_FILTER_EN
  assign mmu_pass = (iMmuAddr >= iFiltLo) && (iMmuAddr <= iFiltHi);
`else
  assign mmu_pass = 1'b1;
`endif

  // Event selection: the trigger flow-start is recorded from ARMED, everything else only in CAPTURE.
  always_comb begin
    trig_hit  = (state_q == ST_ARMED) && iTrigPcEn && iFlowStart && (iPc == iTrigPc);
    cap_en    = (state_q == ST_CAPTURE);
    mmu_cand  = cap_en && iMmuWe && mmu_pass;
    flow_cand = (cap_en && iFlowStart) || trig_hit;
    eof_cand  = cap_en && iEof;
    n_cand    = 2'(mmu_cand) + 2'(flow_cand) + 2'(eof_cand);
    type_sel  = 2'b00;
    addr_sel  = '0;
    data_sel  = '0;
    if (mmu_cand) begin
      type_sel = 2'b10;
      addr_sel = iMmuAddr;
      data_sel = iMmuData;
    end else if (flow_cand) begin
      type_sel = 2'b01;
      addr_sel = iPc;
      data_sel = iOpcode;
    end else if (eof_cand) begin
      type_sel = 2'b11;
      addr_sel = iPc;
      data_sel = iFlags;
    end
    wr_rec = {type_sel, ts_q, addr_sel, data_sel};
  end

  always_comb begin
    full       = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    pop        = rd_valid_q && iRdReady;
    push       = (n_cand != 2'd0) && (!full || pop || iWrapMode) && !iArm;
    ovw        = push && full && !pop;
    mem_we     = push;

    state_d    = state_q;
    ts_d       = (state_q != ST_IDLE) ? ts_q + TS_W'(1) : ts_q;
    wr_ptr_d   = wr_ptr_q + CW'(push);
    rd_ptr_d   = rd_ptr_q + CW'(pop || ovw);
    next_count = wr_ptr_d - rd_ptr_d;

    // Losing coincident events plus any overwritten oldest record are all lost events.
    drop_inc   = (push ? n_cand - 2'd1 : 2'd0) + 2'(ovw);
    drop_sum   = {1'b0, drop_q} + 9'(drop_inc);
    drop_d     = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    unique case (state_q)
      ST_IDLE:    state_d = ST_IDLE;
      ST_ARMED:   if (!iTrigPcEn || trig_hit) state_d = ST_CAPTURE;
      ST_CAPTURE: if (!iWrapMode && (n_cand != 2'd0) && (next_count == CW'(DEPTH)))
                    state_d = ST_FROZEN;
      ST_FROZEN:  state_d = ST_FROZEN;
      default:    state_d = ST_IDLE;
    endcase

    // Output register preloads the next head; bypass when this cycle's write lands on it.
    if (push && (wr_ptr_q == rd_ptr_d)) head = wr_rec;
    else                                head = mem_q[rd_ptr_d[AW-1:0]];
    rd_valid_d = (wr_ptr_d != rd_ptr_d);
    rd_data_d  = rd_valid_d ? head : '0;

    if (iArm) begin
      state_d    = ST_ARMED;
      ts_d       = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      drop_d     = '0;
      rd_valid_d = 1'b0;
      rd_data_d  = '0;
    end
  end

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q    <= ST_IDLE;
      ts_q       <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      drop_q     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      ts_q       <= ts_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      drop_q     <= drop_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  always_ff @(posedge iClock) begin
    if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= wr_rec;
  end

  assign oState   = state_q;
  assign oRdValid = rd_valid_q;
  assign oRdData  = rd_data_q;
  assign oCount   = wr_ptr_q - rd_ptr_q;
  assign oDropCnt = drop_q;

endmodule

// File: tb/tb_dzcpu_trace_buffer.sv
// Scoreboard bench for dzcpu_trace_buffer: expected records queued at stimulus time, compared on drain.
module tb_dzcpu_trace_buffer;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic        iFlowStart = 1'b0;
  logic [15:0] iPc = '0;
  logic [7:0]  iOpcode = '0;
  logic        iMmuWe = 1'b0;
  logic [15:0] iMmuAddr = '0;
  logic [7:0]  iMmuData = '0;
  logic        iEof = 1'b0;
  logic [7:0]  iFlags = '0;
  logic        iArm = 1'b0;
  logic        iTrigPcEn = 1'b0;
  logic [15:0] iTrigPc = '0;
  logic        iWrapMode = 1'b0;
`ifdef TRACE_ADDR_FILTER_EN
  logic [15:0] iFiltLo = '0;
  logic [15:0] iFiltHi = 16'hFFFF;
`endif
  logic [1:0]  oState;
  logic        oRdValid;
  logic        iRdReady = 1'b0;
  logic [41:0] oRdData;
  logic [4:0]  oCount;
  logic [7:0]  oDropCnt;

  int checks = 0;
  int errors = 0;
  logic [41:0] sb[$];
  logic [15:0] m_ts;
  logic        m_act;

  dzcpu_trace_buffer #(.DEPTH(16), .TS_W(16), .ADDR_W(16), .DATA_W(8)) dut (
    .iClock(iClock), .iReset(iReset), .iFlowStart(iFlowStart), .iPc(iPc), .iOpcode(iOpcode),
    .iMmuWe(iMmuWe), .iMmuAddr(iMmuAddr), .iMmuData(iMmuData), .iEof(iEof), .iFlags(iFlags),
    .iArm(iArm), .iTrigPcEn(iTrigPcEn), .iTrigPc(iTrigPc), .iWrapMode(iWrapMode),
`ifdef TRACE_ADDR_FILTER_EN
    .iFiltLo(iFiltLo), .iFiltHi(iFiltHi),
`endif
    .oState(oState), .oRdValid(oRdValid), .iRdReady(iRdReady), .oRdData(oRdData),
    .oCount(oCount), .oDropCnt(oDropCnt)
  );

  always #5 iClock = ~iClock;

  // Timestamp model: cleared by arm, free-running afterwards.
  always @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      m_ts  <= '0;
      m_act <= 1'b0;
    end else if (iArm) begin
      m_ts  <= '0;
      m_act <= 1'b1;
    end else if (m_act) begin
      m_ts  <= m_ts + 16'd1;
    end
  end

  task automatic ev(input logic we, input logic [15:0] ma, input logic [7:0] md,
                    input logic fs, input logic [15:0] pc, input logic [7:0] op,
                    input logic eof, input logic [7:0] fl);
    iMmuWe = we; iMmuAddr = ma; iMmuData = md;
    iFlowStart = fs; iPc = pc; iOpcode = op;
    iEof = eof; iFlags = fl;
  endtask

  task automatic clr();
    ev(1'b0, 16'h0, 8'h0, 1'b0, 16'h0, 8'h0, 1'b0, 8'h0);
  endtask

  task automatic exp_push(input logic [1:0] ty, input logic [15:0] a, input logic [7:0] d);
    sb.push_back({ty, m_ts, a, d});
  endtask

  task automatic arm(input logic trig_en, input logic [15:0] trig_pc, input logic wrap);
    @(negedge iClock);
    clr();
    iArm = 1'b1; iTrigPcEn = trig_en; iTrigPc = trig_pc; iWrapMode = wrap;
    sb.delete();
    @(negedge iClock);
    iArm = 1'b0;
  endtask

  task automatic drain(input string name);
    @(negedge iClock);
    clr();
    iRdReady = 1'b1;
    for (int g = 0; g < 64; g++) begin
      if (!oRdValid) break;
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL %s_extra: got %h want no record", name, oRdData);
      end else begin
        if (oRdData !== sb[0]) begin
          errors++;
          $display("FAIL %s_rec: got %h want %h", name, oRdData, sb[0]);
        end
        void'(sb.pop_front());
      end
      @(negedge iClock);
    end
    iRdReady = 1'b0;
    checks++;
    if (sb.size() != 0 || oRdValid !== 1'b0) begin
      errors++;
      $display("FAIL %s_left: got %0d pending, valid %b want 0 pending, valid 0", name, sb.size(), oRdValid);
    end
  endtask

  task automatic test_reset();
    iReset = 1'b1;
    repeat (2) @(negedge iClock);
    iReset = 1'b0;
    @(negedge iClock);
    checks++; if (oState !== 2'b00) begin errors++; $display("FAIL rst_state: got %b want 00", oState); end
    checks++; if (oCount !== 5'd0) begin errors++; $display("FAIL rst_count: got %0d want 0", oCount); end
    checks++; if (oRdValid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", oRdValid); end
    checks++; if (oRdData !== 42'd0) begin errors++; $display("FAIL rst_data: got %h want 0", oRdData); end
    checks++; if (oDropCnt !== 8'd0) begin errors++; $display("FAIL rst_drop: got %0d want 0", oDropCnt); end
  endtask

  task automatic test_trigger();
    arm(1'b1, 16'h0150, 1'b0);
    checks++; if (oState !== 2'b01) begin errors++; $display("FAIL trig_armed: got %b want 01", oState); end
    @(negedge iClock); ev(1'b0, 16'h0, 8'h0, 1'b1, 16'h0100, 8'h00, 1'b0, 8'h0);
    @(negedge iClock);
    checks++; if (oState !== 2'b01) begin errors++; $display("FAIL trig_wait: got %b want 01", oState); end
    ev(1'b0, 16'h0, 8'h0, 1'b1, 16'h0150, 8'hC3, 1'b0, 8'h0);
    exp_push(2'b01, 16'h0150, 8'hC3);
    @(negedge iClock); clr();
    checks++; if (oState !== 2'b10) begin errors++; $display("FAIL trig_capture: got %b want 10", oState); end
    ev(1'b1, 16'h1234, 8'h55, 1'b0, 16'h0, 8'h0, 1'b0, 8'h0);
    exp_push(2'b10, 16'h1234, 8'h55);
    @(negedge iClock);
    ev(1'b0, 16'h0, 8'h0, 1'b0, 16'h0200, 8'h0, 1'b1, 8'hA5);
    exp_push(2'b11, 16'h0200, 8'hA5);
    @(negedge iClock); clr();
    checks++; if (oCount !== 5'd3) begin errors++; $display("FAIL trig_count: got %0d want 3", oCount); end
    drain("trig");
  endtask

  task automatic test_reset_mid();
    arm(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge iClock); ev(1'b1, 16'hC000 + 16'(i), 8'(i), 1'b0, 16'h0, 8'h0, 1'b0, 8'h0);
    end
    @(negedge iClock); ev(1'b1, 16'hC100, 8'h0, 1'b0, 16'h0, 8'h0, 1'b1, 8'h0);
    @(negedge iClock); clr();
    checks++; if (oCount !== 5'd6) begin errors++; $display("FAIL mid_count_pre: got %0d want 6", oCount); end
    checks++; if (oDropCnt !== 8'd1) begin errors++; $display("FAIL mid_drop_pre: got %0d want 1", oDropCnt); end
    iReset = 1'b1;
    @(negedge iClock);
    checks++; if (oState !== 2'b00) begin errors++; $display("FAIL mid_state: got %b want 00", oState); end
    checks++; if (oCount !== 5'd0) begin errors++; $display("FAIL mid_count: got %0d want 0", oCount); end
    checks++; if (oRdValid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b want 0", oRdValid); end
    checks++; if (oDropCnt !== 8'd0) begin errors++; $display("FAIL mid_drop: got %0d want 0", oDropCnt); end
    iReset = 1'b0;
    sb.delete();
  endtask

  task automatic test_stop_full();
    arm(1'b0, 16'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge iClock); ev(1'b1, 16'hFF40 + 16'(i), 8'(i), 1'b0, 16'h0, 8'h0, 1'b0, 8'h0);
      if (i < 16) exp_push(2'b10, 16'hFF40 + 16'(i), 8'(i));
    end
    @(negedge iClock); clr();
    checks++; if (oState !== 2'b11) begin errors++; $display("FAIL full_state: got %b want 11", oState); end
    checks++; if (oCount !== 5'd16) begin errors++; $display("FAIL full_count: got %0d want 16", oCount); end
    checks++; if (oDropCnt !== 8'd0) begin errors++; $display("FAIL full_drop: got %0d want 0", oDropCnt); end
    checks++; if (sb[15][23:8] !== 16'hFF4F) begin errors++; $display("FAIL full_last_model: got %h want ff4f", sb[15][23:8]); end
    drain("full");
    checks++; if (oState !== 2'b11) begin errors++; $display("FAIL full_frozen_after: got %b want 11", oState); end
  endtask

  task automatic test_wrap();
    arm(1'b0, 16'h0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      @(negedge iClock); ev(1'b1, 16'hFF40 + 16'(i), 8'(i), 1'b0, 16'h0, 8'h0, 1'b0, 8'h0);
      exp_push(2'b10, 16'hFF40 + 16'(i), 8'(i));
    end
    repeat (4) void'(sb.pop_front());
    @(negedge iClock); clr();
    checks++; if (oState !== 2'b10) begin errors++; $display("FAIL wrap_state: got %b want 10", oState); end
    checks++; if (oCount !== 5'd16) begin errors++; $display("FAIL wrap_count: got %0d want 16", oCount); end
    checks++; if (oDropCnt !== 8'd4) begin errors++; $display("FAIL wrap_drop: got %0d want 4", oDropCnt); end
    checks++; if (oRdData[23:8] !== 16'hFF44) begin errors++; $display("FAIL wrap_oldest: got %h want ff44", oRdData[23:8]); end
    // full in wrap mode with a simultaneous pop: pop wins, push kept, no drop
    @(negedge iClock);
    checks++; if (oRdData !== sb[0]) begin errors++; $display("FAIL wrap_bb_head: got %h want %h", oRdData, sb[0]); end
    void'(sb.pop_front());
    iRdReady = 1'b1;
    ev(1'b1, 16'hFF60, 8'h60, 1'b0, 16'h0, 8'h0, 1'b0, 8'h0);
    exp_push(2'b10, 16'hFF60, 8'h60);
    @(negedge iClock); clr(); iRdReady = 1'b0;
    checks++; if (oCount !== 5'd16) begin errors++; $display("FAIL wrap_bb_count: got %0d want 16", oCount); end
    checks++; if (oDropCnt !== 8'd4) begin errors++; $display("FAIL wrap_bb_drop: got %0d want 4", oDropCnt); end
    drain("wrap");
  endtask

  task automatic test_collision();
    arm(1'b0, 16'h0, 1'b0);
    @(negedge iClock); ev(1'b1, 16'h2000, 8'h11, 1'b0, 16'h0300, 8'h0, 1'b1, 8'h0F);
    exp_push(2'b10, 16'h2000, 8'h11);
    @(negedge iClock); clr();
    checks++; if (oDropCnt !== 8'd1) begin errors++; $display("FAIL coll_drop: got %0d want 1", oDropCnt); end
    checks++; if (oCount !== 5'd1) begin errors++; $display("FAIL coll_count: got %0d want 1", oCount); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (oRdValid !== 1'b1 || oRdData !== sb[0]) begin
        errors++; $display("FAIL coll_hold: got %b/%h want 1/%h", oRdValid, oRdData, sb[0]);
      end
      @(negedge iClock);
    end
    ev(1'b0, 16'h0, 8'h0, 1'b1, 16'h0400, 8'h77, 1'b1, 8'h01);
    exp_push(2'b01, 16'h0400, 8'h77);
    @(negedge iClock); ev(1'b1, 16'h2100, 8'h22, 1'b1, 16'h0500, 8'h88, 1'b1, 8'h02);
    exp_push(2'b10, 16'h2100, 8'h22);
    @(negedge iClock); clr();
    checks++; if (oDropCnt !== 8'd4) begin errors++; $display("FAIL coll_drop3: got %0d want 4", oDropCnt); end
    checks++; if (oCount !== 5'd3) begin errors++; $display("FAIL coll_count3: got %0d want 3", oCount); end
    drain("coll");
  endtask

  task automatic test_back_to_back();
    bit done = 1'b0;
    arm(1'b0, 16'h0, 1'b0);
    iRdReady = 1'b1;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          @(negedge iClock); ev(1'b1, 16'h4000 + 16'(i), 8'(8'hA0 + i), 1'b0, 16'h0, 8'h0, 1'b0, 8'h0);
          exp_push(2'b10, 16'h4000 + 16'(i), 8'(8'hA0 + i));
        end
        @(negedge iClock); clr();
        done = 1'b1;
      end
      begin
        for (int k = 0; k < 60; k++) begin
          @(negedge iClock);
          if (oRdValid) begin
            checks++;
            if (sb.size() == 0 || oRdData !== sb[0]) begin
              errors++; $display("FAIL b2b_rec: got %h want %h", oRdData, (sb.size() != 0) ? sb[0] : 42'd0);
            end
            if (sb.size() != 0) void'(sb.pop_front());
          end else if (done && sb.size() == 0) begin
            break;
          end
        end
      end
    join
    iRdReady = 1'b0;
    checks++; if (sb.size() != 0) begin errors++; $display("FAIL b2b_left: got %0d pending want 0", sb.size()); end
    checks++; if (oCount !== 5'd0) begin errors++; $display("FAIL b2b_count: got %0d want 0", oCount); end
    checks++; if (oDropCnt !== 8'd0) begin errors++; $display("FAIL b2b_drop: got %0d want 0", oDropCnt); end
  endtask

`ifdef TRACE_ADDR_FILTER_EN
  task automatic test_filter();
    iFiltLo = 16'h8000; iFiltHi = 16'h87FF;
    arm(1'b0, 16'h0, 1'b0);
    @(negedge iClock); ev(1'b1, 16'h8000, 8'h01, 1'b0, 16'h0, 8'h0, 1'b0, 8'h0);
    exp_push(2'b10, 16'h8000, 8'h01);
    @(negedge iClock); ev(1'b1, 16'h9000, 8'h02, 1'b0, 16'h0, 8'h0, 1'b0, 8'h0);
    @(negedge iClock); ev(1'b1, 16'h87FF, 8'h03, 1'b0, 16'h0, 8'h0, 1'b0, 8'h0);
    exp_push(2'b10, 16'h87FF, 8'h03);
    @(negedge iClock); ev(1'b1, 16'h7FFF, 8'h04, 1'b0, 16'h0600, 8'h0, 1'b1, 8'h3C);
    exp_push(2'b11, 16'h0600, 8'h3C);
    @(negedge iClock); clr();
    checks++; if (oCount !== 5'd3) begin errors++; $display("FAIL filt_count: got %0d want 3", oCount); end
    checks++; if (oDropCnt !== 8'd0) begin errors++; $display("FAIL filt_drop: got %0d want 0", oDropCnt); end
    drain("filt");
    iFiltLo = '0; iFiltHi = 16'hFFFF;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_trigger();
    test_reset_mid();
    test_stop_full();
    test_wrap();
    test_collision();
    test_back_to_back();
`ifdef TRACE_ADDR_FILTER_EN
    test_filter();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
